sprite_motion: RTL and testbench
================================

SPRITE_MOTION -- requirements
Module: sprite_motion

Interface
REQ-001 Parameter X_MAX, default 160, screen width in pixels.
REQ-002 Parameter Y_MAX, default 120, screen height in pixels.
REQ-003 Parameter SIZE, default 4, sprite edge length in pixels.
REQ-004 Parameter STEP, default 1, pixels moved per update (1..SIZE).
REQ-005 Parameters X_INIT / Y_INIT, default 0 / 0, position after reset.
REQ-006 clock  input  1  single system clock; all logic on rising edge.
REQ-007 resetn  input  1  reset, synchronous and active-low.
REQ-008 iUpdate  input  1  one-cycle pulse from the box drawer at the end of each erase.
REQ-009 iLeft / iRight / iUp / iDown  input  1 each  active-high manual direction requests, level-sensitive.
REQ-010 iAutoMode  input  1  1 = autonomous bounce, 0 = manual.
REQ-011 iColour  input  3  sprite colour.
REQ-012 iReady  input  1  drawer accepts the offered position.
REQ-013 oX  output  8  sprite top-left x.
REQ-014 oY  output  7  sprite top-left y.
REQ-015 oColour  output  3  sprite colour.
REQ-016 oValid  output  1  new position offered to drawer.
REQ-017 oHitEdge  output  1  one-cycle pulse when a move reaches or is blocked by a screen edge.

Function
REQ-018 FSM states: IDLE, CALC, OFFER; IDLE->CALC on iUpdate; CALC->OFFER unconditionally; OFFER->IDLE in the cycle oValid && iReady.
REQ-019 oValid = 1 only in OFFER; oX/oY/oColour stable while oValid = 1.
REQ-020 iUpdate outside IDLE is ignored; no queuing.
REQ-021 In CALC, iAutoMode, iColour and the direction inputs are sampled; new oX/oY/oColour are registered at the end of CALC (latency iUpdate->oValid = 2 cycles).
REQ-022 Bounds: XLIM = X_MAX-SIZE (156), YLIM = Y_MAX-SIZE (116); oX in [0,XLIM], oY in [0,YLIM] at all times.
REQ-023 Manual mode: dx = iRight-iLeft, dy = iDown-iUp; both opposing inputs high gives 0 on that axis.
REQ-024 Manual mode: new coordinate = old ± STEP, clamped to [0,LIM]; oHitEdge pulses if any requested axis move was clamped or lands exactly on 0/LIM.
REQ-025 Auto mode: internal dirX, dirY (1 = increasing); per axis, if dir=1 and old+STEP >= LIM -> coord = LIM, dir = 0, hit; if dir=0 and old <= STEP -> coord = 0, dir = 1, hit; otherwise coord moves STEP along dir.
REQ-026 Auto-mode corner (both axes hit in the same CALC): both dirs flip, single oHitEdge pulse.
REQ-027 dirX/dirY hold their values in manual mode; switching mode takes effect at the next CALC.
REQ-028 oHitEdge asserted only in the cycle after CALC (first OFFER cycle), otherwise 0.
REQ-029 Arithmetic performed at 9-bit (x) / 8-bit (y) width before clamping; no wrap-around permitted.

Reset
REQ-030 resetn = 0 at a rising edge: state = IDLE, oX = X_INIT, oY = Y_INIT, oColour = 0, oValid = 0, oHitEdge = 0, dirX = 1, dirY = 1.
REQ-031 Reset in CALC or OFFER aborts the move; the pending position is discarded.

Structure
REQ-032 X_MAX, Y_MAX, SIZE defaults and the FSM state encoding reside in the shared display package used by the box drawer.
REQ-033 One sub-module, axis_step, instantiated twice (x, y): inputs old coord, dir/request, mode, LIM; outputs new coord, new dir, hit.
REQ-034 Outputs are registered; no combinational path from inputs to outputs.

Verification
REQ-035 Reset, then iUpdate with iAutoMode = 1, iReady = 1 -> after 2 cycles oValid = 1, oX = 1, oY = 1, oHitEdge = 0.
REQ-036 Auto mode, oX = 155, dirX = 1, iUpdate -> oX = 156, dirX = 0, oHitEdge pulse; next update -> oX = 155.
REQ-037 Auto mode corner oX = 155, oY = 115, both dirs 1 -> oX = 156, oY = 116, one oHitEdge pulse, both dirs 0.
REQ-038 Manual mode, oX = 0, iLeft = 1, iUp = 1, iUpdate -> oX = 0, oY = 0, oHitEdge pulse; iLeft = iRight = 1 -> oX unchanged.
REQ-039 iReady held 0 for 10 cycles in OFFER with iUpdate pulsed twice -> oValid stays 1, oX/oY unchanged, second iUpdate ignored.
REQ-040 resetn = 0 during OFFER -> next cycle oValid = 0, oX = X_INIT, oY = Y_INIT, state IDLE.

Source files
------------

// File: rtl/sprite_motion_pkg.sv
// ---------------------------------------------------------------------------
// sprite_motion_pkg
// Shared display package. The box drawer and the sprite motion block both use
// it, so the screen geometry defaults and the motion FSM state encoding are
// defined once here.
//   DISP_X_MAX / DISP_Y_MAX : screen width / height in pixels
//   DISP_SIZE               : sprite edge length in pixels
//   motion_state_e          : IDLE -> CALC -> OFFER handshake sequence
// ---------------------------------------------------------------------------
package sprite_motion_pkg;

  localparam int DISP_X_MAX = 160;
  localparam int DISP_Y_MAX = 120;
  localparam int DISP_SIZE  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_OFFER = 2'd2
  } motion_state_e;

endpackage

// File: rtl/sprite_motion_axis_step.sv
// ---------------------------------------------------------------------------
// axis_step
// Purely combinational single-axis position update, used once for x and
// once for y.
//   old_coord  : current coordinate (CW bits)
//   lim        : highest legal coordinate (screen size minus sprite size)
//   dir_in     : autonomous direction, 1 = increasing
//   req_inc    : manual request to increase (right / down)
//   req_dec    : manual request to decrease (left / up)
//   auto_mode  : 1 = bounce using dir_in, 0 = follow the manual requests
//   new_coord  : updated coordinate, always inside [0, lim]
//   new_dir    : updated autonomous direction (flips on a bounce only)
//   hit        : the move was clamped or landed exactly on 0 / lim
// The sum is formed one bit wider than the coordinate, so a step past the
// top of the coordinate range is compared correctly instead of wrapping.
// ---------------------------------------------------------------------------
module axis_step #(
  parameter int CW   = 8,
  parameter int STEP = 1
) (
  input  logic [CW-1:0] old_coord,
  input  logic [CW-1:0] lim,
  input  logic          dir_in,
  input  logic          req_inc,
  input  logic          req_dec,
  input  logic          auto_mode,
  output logic [CW-1:0] new_coord,
  output logic          new_dir,
  output logic          hit
);

  localparam logic [CW:0]   STEP_W = (CW+1)'(STEP);
  localparam logic [CW-1:0] STEP_N = CW'(STEP);

  logic          move_inc;
  logic          move_dec;
  logic [CW:0]   old_w;
  logic [CW:0]   sum_w;

  always_comb begin
    old_w     = {1'b0, old_coord};
    sum_w     = old_w + STEP_W;
    // Opposing manual requests cancel; in auto mode exactly one of the two
    // moves is active, chosen by the stored direction.
    move_inc  = auto_mode ? dir_in  : (req_inc & ~req_dec);
    move_dec  = auto_mode ? ~dir_in : (req_dec & ~req_inc);
    new_coord = old_coord;
    hit       = 1'b0;
    if (move_inc) begin
      if (sum_w >= {1'b0, lim}) begin
        new_coord = lim;
        hit       = 1'b1;
      end else begin
        new_coord = sum_w[CW-1:0];
      end
    end else if (move_dec) begin
      if (old_w <= STEP_W) begin
        new_coord = '0;
        hit       = 1'b1;
      end else begin
        new_coord = old_coord - STEP_N;
      end
    end
    // Manual moves never disturb the bounce direction.
    new_dir = (auto_mode && hit) ? ~dir_in : dir_in;
  end

endmodule

// File: rtl/sprite_motion.sv
// ---------------------------------------------------------------------------
// sprite_motion
// Moves a square sprite around the screen, either under manual direction
// control or bouncing autonomously off the screen edges. Each iUpdate pulse
// from the box drawer (end of erase) computes one move and offers the new
// position back to the drawer with a valid/ready handshake.
//   clock, resetn      : system clock, synchronous active-low reset
//   iUpdate            : one-cycle pulse, start a move (ignored unless idle)
//   iLeft/iRight/iUp/iDown : manual direction levels
//   iAutoMode          : 1 = bounce, 0 = manual
//   iColour            : sprite colour, captured with the move
//   iReady             : drawer accepts the offered position
//   oX, oY, oColour    : registered sprite top-left position and colour
//   oValid             : new position on offer
//   oHitEdge           : one-cycle pulse in the first offer cycle when the
//                        move touched or was blocked by an edge
//   dbg_state          : current FSM state (motion_state_e encoding)
//   dbg_dir            : {dir_x, dir_y} autonomous directions
// Handshake: oValid rises in OFFER and stays high with oX/oY/oColour frozen
// until a rising edge where oValid && iReady, which completes the transfer.
// ---------------------------------------------------------------------------
module sprite_motion
  import sprite_motion_pkg::*;
#(
  parameter int X_MAX  = DISP_X_MAX,
  parameter int Y_MAX  = DISP_Y_MAX,
  parameter int SIZE   = DISP_SIZE,
  parameter int STEP   = 1,
  parameter int X_INIT = 0,
  parameter int Y_INIT = 0
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       iUpdate,
  input  logic       iLeft,
  input  logic       iRight,
  input  logic       iUp,
  input  logic       iDown,
  input  logic       iAutoMode,
  input  logic [2:0] iColour,
  input  logic       iReady,
  output logic [7:0] oX,
  output logic [6:0] oY,
  output logic [2:0] oColour,
  output logic       oValid,
  output logic       oHitEdge,
  output logic [1:0] dbg_state,
  output logic [1:0] dbg_dir
);

  localparam logic [7:0] XLIM = 8'(X_MAX - SIZE);
  localparam logic [6:0] YLIM = 7'(Y_MAX - SIZE);

  motion_state_e state_q, state_d;
  logic [7:0]    x_q, x_d;
  logic [6:0]    y_q, y_d;
  logic [2:0]    colour_q, colour_d;
  logic          dir_x_q, dir_x_d;
  logic          dir_y_q, dir_y_d;
  logic          hit_q, hit_d;

  logic [7:0]    new_x;
  logic [6:0]    new_y;
  logic          new_dir_x, new_dir_y;
  logic          hit_x, hit_y;

  axis_step #(.CW(8), .STEP(STEP)) u_x_step (
    .old_coord (x_q),
    .lim       (XLIM),
    .dir_in    (dir_x_q),
    .req_inc   (iRight),
    .req_dec   (iLeft),
    .auto_mode (iAutoMode),
    .new_coord (new_x),
    .new_dir   (new_dir_x),
    .hit       (hit_x)
  );

  axis_step #(.CW(7), .STEP(STEP)) u_y_step (
    .old_coord (y_q),
    .lim       (YLIM),
    .dir_in    (dir_y_q),
    .req_inc   (iDown),
    .req_dec   (iUp),
    .auto_mode (iAutoMode),
    .new_coord (new_y),
    .new_dir   (new_dir_y),
    .hit       (hit_y)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    hit_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (iUpdate) state_d = ST_CALC;
      end
      ST_CALC: begin
        // All move inputs are sampled here; the result is frozen for OFFER.
        state_d  = ST_OFFER;
        x_d      = new_x;
        y_d      = new_y;
        colour_d = iColour;
        dir_x_d  = new_dir_x;
        dir_y_d  = new_dir_y;
        // A corner bounce still gives a single pulse.
        hit_d    = hit_x | hit_y;
      end
      ST_OFFER: begin
        if (iReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      x_q      <= 8'(X_INIT);
      y_q      <= 7'(Y_INIT);
      colour_q <= 3'd0;
      dir_x_q  <= 1'b1;
      dir_y_q  <= 1'b1;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      dir_x_q  <= dir_x_d;
      dir_y_q  <= dir_y_d;
      hit_q    <= hit_d;
    end
  end

  assign oX        = x_q;
  assign oY        = y_q;
  assign oColour   = colour_q;
  assign oValid    = (state_q == ST_OFFER);
  assign oHitEdge  = hit_q;
  assign dbg_state = state_q;
  assign dbg_dir   = {dir_x_q, dir_y_q};

endmodule

// File: tb/tb_sprite_motion.sv
// ---------------------------------------------------------------------------
// tb_sprite_motion
// Directed bench for sprite_motion with default parameters (160x120 screen,
// 4-pixel sprite, step 1, start at 0,0). Each table entry is one complete
// update transaction with its hand-computed result; the entries form a
// continuous walk, so each depends on the position left by the previous one.
// Stall, reset-in-OFFER and reset-in-CALC are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_sprite_motion;
  import sprite_motion_pkg::*;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       iUpdate = 1'b0;
  logic       iLeft = 1'b0, iRight = 1'b0, iUp = 1'b0, iDown = 1'b0;
  logic       iAutoMode = 1'b0;
  logic [2:0] iColour = 3'd0;
  logic       iReady = 1'b1;
  logic [7:0] oX;
  logic [6:0] oY;
  logic [2:0] oColour;
  logic       oValid;
  logic       oHitEdge;
  logic [1:0] dbg_state;
  logic [1:0] dbg_dir;

  int total = 0;
  int bad   = 0;

  sprite_motion dut (
    .clock     (clock),
    .resetn    (resetn),
    .iUpdate   (iUpdate),
    .iLeft     (iLeft),
    .iRight    (iRight),
    .iUp       (iUp),
    .iDown     (iDown),
    .iAutoMode (iAutoMode),
    .iColour   (iColour),
    .iReady    (iReady),
    .oX        (oX),
    .oY        (oY),
    .oColour   (oColour),
    .oValid    (oValid),
    .oHitEdge  (oHitEdge),
    .dbg_state (dbg_state),
    .dbg_dir   (dbg_dir)
  );

  // Clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       am, l, r, u, d;
    logic [2:0] col;
    int         ex, ey;
    logic       eh;
    logic [1:0] edir;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic am, l, r, u, d, input logic [2:0] col,
                              input int ex, ey, input logic eh, input logic [1:0] edir);
    vec_t v;
    v.am = am; v.l = l; v.r = r; v.u = u; v.d = d; v.col = col;
    v.ex = ex; v.ey = ey; v.eh = eh; v.edir = edir;
    return v;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // One full transaction with iReady high. Checks the protocol timing
  // (CALC cycle, first OFFER cycle, return to IDLE) and returns what was
  // on offer in the first OFFER cycle.
  task automatic run_update(input logic am, l, r, u, d, input logic [2:0] col,
                            output int gx, gy, gc, gh, gdir);
    iAutoMode = am; iLeft = l; iRight = r; iUp = u; iDown = d;
    iColour = col; iReady = 1'b1; iUpdate = 1'b1;
    @(posedge clock); #1;
    iUpdate = 1'b0;
    chk("calc_state", int'(dbg_state), int'(ST_CALC));
    chk("calc_valid", int'(oValid), 0);
    chk("calc_hit", int'(oHitEdge), 0);
    @(posedge clock); #1;
    chk("offer_valid", int'(oValid), 1);
    gx = int'(oX); gy = int'(oY); gc = int'(oColour);
    gh = int'(oHitEdge); gdir = int'(dbg_dir);
    @(posedge clock); #1;
    chk("done_valid", int'(oValid), 0);
    chk("done_hit", int'(oHitEdge), 0);
  endtask

  task automatic apply_vec(input int i);
    int gx, gy, gc, gh, gdir;
    run_update(vecs[i].am, vecs[i].l, vecs[i].r, vecs[i].u, vecs[i].d, vecs[i].col,
               gx, gy, gc, gh, gdir);
    chk($sformatf("v%0d_x", i), gx, vecs[i].ex);
    chk($sformatf("v%0d_y", i), gy, vecs[i].ey);
    chk($sformatf("v%0d_colour", i), gc, int'(vecs[i].col));
    chk($sformatf("v%0d_hit", i), gh, int'(vecs[i].eh));
    chk($sformatf("v%0d_dir", i), gdir, int'(vecs[i].edir));
  endtask

  initial begin
    int gx, gy, gc, gh, gdir;

    //          am  l  r  u  d  col   x    y  hit dir
    vecs[0]  = mk(1, 0, 0, 0, 0, 3'd5,   1,   1, 0, 2'b11); // first auto move
    vecs[1]  = mk(0, 0, 1, 0, 1, 3'd2,   2,   2, 0, 2'b11);
    vecs[2]  = mk(0, 1, 0, 1, 0, 3'd3,   1,   1, 0, 2'b11);
    vecs[3]  = mk(0, 1, 0, 1, 0, 3'd3,   0,   0, 1, 2'b11); // lands on 0
    vecs[4]  = mk(0, 1, 0, 1, 0, 3'd3,   0,   0, 1, 2'b11); // clamped at 0
    vecs[5]  = mk(0, 1, 1, 1, 1, 3'd4,   0,   0, 0, 2'b11); // opposing cancel
    vecs[6]  = mk(0, 0, 1, 0, 0, 3'd1,   1,   0, 0, 2'b11);
    vecs[7]  = mk(0, 1, 1, 0, 1, 3'd1,   1,   1, 0, 2'b11);
    vecs[8]  = mk(1, 0, 0, 0, 0, 3'd6,   2,   2, 0, 2'b11);
    // from 155,115 with both dirs still increasing
    vecs[9]  = mk(1, 0, 0, 0, 0, 3'd7, 156, 116, 1, 2'b00); // corner bounce
    vecs[10] = mk(1, 0, 0, 0, 0, 3'd7, 155, 115, 0, 2'b00);
    vecs[11] = mk(0, 0, 1, 0, 0, 3'd0, 156, 115, 1, 2'b00); // lands on XLIM
    vecs[12] = mk(0, 0, 1, 0, 1, 3'd0, 156, 116, 1, 2'b00); // clamped at XLIM
    vecs[13] = mk(0, 1, 0, 0, 0, 3'd2, 155, 116, 0, 2'b00);
    vecs[14] = mk(1, 0, 0, 0, 0, 3'd2, 154, 115, 0, 2'b00);

    // Reset
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_state", int'(dbg_state), int'(ST_IDLE));
    chk("rst_x", int'(oX), 0);
    chk("rst_y", int'(oY), 0);
    chk("rst_colour", int'(oColour), 0);
    chk("rst_valid", int'(oValid), 0);
    chk("rst_hit", int'(oHitEdge), 0);
    chk("rst_dir", int'(dbg_dir), 3);
    resetn = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 9; i++) apply_vec(i);

    // Walk to 155,115 manually; directions must survive manual moves.
    for (int i = 0; i < 113; i++) run_update(0, 0, 1, 0, 1, 3'd1, gx, gy, gc, gh, gdir);
    for (int i = 0; i < 40; i++)  run_update(0, 0, 1, 0, 0, 3'd1, gx, gy, gc, gh, gdir);
    chk("walk_x", gx, 155);
    chk("walk_y", gy, 115);
    chk("walk_hit", gh, 0);
    chk("walk_dir", gdir, 3);

    for (int i = 9; i < 15; i++) apply_vec(i);

    // Stall in OFFER for 10 cycles with two ignored update pulses.
    iAutoMode = 1'b0; iLeft = 1'b0; iRight = 1'b1; iUp = 1'b0; iDown = 1'b0;
    iColour = 3'd5; iReady = 1'b0; iUpdate = 1'b1;
    @(posedge clock); #1;
    iUpdate = 1'b0;
    @(posedge clock); #1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("stall%0d_valid", i), int'(oValid), 1);
      chk($sformatf("stall%0d_x", i), int'(oX), 155);
      chk($sformatf("stall%0d_y", i), int'(oY), 115);
      chk($sformatf("stall%0d_colour", i), int'(oColour), 5);
      iUpdate = (i == 2 || i == 5);
      iLeft = (i > 0); // inputs after CALC must not matter
      @(posedge clock); #1;
    end
    iUpdate = 1'b0; iLeft = 1'b0;
    chk("stall_end_valid", int'(oValid), 1);
    iReady = 1'b1;
    @(posedge clock); #1;
    chk("accept_valid", int'(oValid), 0);
    chk("accept_state", int'(dbg_state), int'(ST_IDLE));
    @(posedge clock); #1;
    chk("no_queue_state", int'(dbg_state), int'(ST_IDLE));
    chk("no_queue_x", int'(oX), 155);
    chk("no_queue_y", int'(oY), 115);

    // Reset while offering.
    iAutoMode = 1'b1; iRight = 1'b0; iReady = 1'b0; iUpdate = 1'b1;
    @(posedge clock); #1;
    iUpdate = 1'b0;
    @(posedge clock); #1;
    chk("pre_rst_valid", int'(oValid), 1);
    resetn = 1'b0;
    @(posedge clock); #1;
    chk("rst_offer_valid", int'(oValid), 0);
    chk("rst_offer_x", int'(oX), 0);
    chk("rst_offer_y", int'(oY), 0);
    chk("rst_offer_state", int'(dbg_state), int'(ST_IDLE));
    chk("rst_offer_dir", int'(dbg_dir), 3);
    chk("rst_offer_colour", int'(oColour), 0);
    resetn = 1'b1; iReady = 1'b1;
    @(posedge clock); #1;

    // Reset while calculating: the pending move is discarded.
    iAutoMode = 1'b1; iColour = 3'd6; iUpdate = 1'b1;
    @(posedge clock); #1;
    iUpdate = 1'b0;
    chk("pre_rst_calc_state", int'(dbg_state), int'(ST_CALC));
    resetn = 1'b0;
    @(posedge clock); #1;
    resetn = 1'b1;
    chk("rst_calc_state", int'(dbg_state), int'(ST_IDLE));
    chk("rst_calc_x", int'(oX), 0);
    chk("rst_calc_y", int'(oY), 0);
    @(posedge clock); #1;
    chk("rst_calc_valid", int'(oValid), 0);
    chk("rst_calc_state2", int'(dbg_state), int'(ST_IDLE));

    // Fresh move after the aborted one behaves as the first move.
    run_update(1, 0, 0, 0, 0, 3'd6, gx, gy, gc, gh, gdir);
    chk("post_rst_x", gx, 1);
    chk("post_rst_y", gy, 1);
    chk("post_rst_colour", gc, 6);
    chk("post_rst_hit", gh, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
